// File: rtl/pad_scan_controller.sv
// pad_scan_controller: autonomous serial gamepad scanner driving latch/clock and publishing 16-bit button words.
// Optional build macro PAD_SCAN_CONTROLLER_EDGE_EN adds pad_pressed_0/1 (newly pressed buttons per scan).
module pad_scan_controller #(
    parameter int LATCH_CYCLES = 96,
    parameter int CLK_DIV      = 48,
    parameter int SCAN_BITS    = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_trigger,
    input  logic        host_start,
    input  logic        pad_data_0,
    input  logic        pad_data_1,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] pad_state_0,
    output logic [15:0] pad_state_1,
    output logic        busy,
    output logic        state_valid,
    output logic        scan_done
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
    ,
    output logic [15:0] pad_pressed_0,
    output logic [15:0] pad_pressed_1
`endif
);
    localparam int MAX_CNT = LATCH_CYCLES > CLK_DIV ? LATCH_CYCLES : CLK_DIV;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD   = CW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_BIT   = 4'(SCAN_BITS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH    = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          pend_q, pend_d;
    logic [1:0]    sync0_q, sync1_q;
    logic [15:0]   sr0_q, sr0_d, sr1_q, sr1_d;
    logic [15:0]   st0_q, st0_d, st1_q, st1_d;
    logic          valid_q, valid_d;
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
    logic [15:0]   pr0_q, pr0_d, pr1_q, pr1_d;
    assign pad_pressed_0 = pr0_q;
    assign pad_pressed_1 = pr1_q;
`endif

    logic req;
    assign req         = frame_trigger | host_start;
    assign pad_latch   = state_q == S_LATCH;
    assign pad_clk     = state_q != S_SHIFT_LO;
    assign busy        = state_q != S_IDLE;
    assign scan_done   = state_q == S_DONE;
    assign state_valid = valid_q;
    assign pad_state_0 = st0_q;
    assign pad_state_1 = st1_q;

    // Scan sequencing; published words are loaded on the edge entering DONE so they appear together with scan_done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pend_d  = pend_q | (req && state_q != S_IDLE);
        sr0_d   = sr0_q;
        sr1_d   = sr1_q;
        st0_d   = st0_q;
        st1_d   = st1_q;
        valid_d = valid_q;
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
        pr0_d   = pr0_q;
        pr1_d   = pr1_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req || pend_q) begin
                    state_d = S_LATCH;
                    pend_d  = 1'b0;
                    cnt_d   = LATCH_LOAD;
                    bit_d   = '0;
                end
            end
            S_LATCH: begin
                state_d = cnt_q == '0 ? S_SHIFT_LO : S_LATCH;
                cnt_d   = cnt_q == '0 ? DIV_LOAD : cnt_q - 1'b1;
            end
            S_SHIFT_LO: begin
                if (cnt_q == '0) begin
                    sr0_d[bit_q] = ~sync0_q[1];
                    sr1_d[bit_q] = ~sync1_q[1];
                    state_d      = S_SHIFT_HI;
                    cnt_d        = DIV_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (bit_q == LAST_BIT) begin
                    state_d = S_DONE;
                    st0_d   = sr0_q;
                    st1_d   = sr1_q;
                    valid_d = 1'b1;
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
                    pr0_d   = sr0_q & ~st0_q;
                    pr1_d   = sr1_q & ~st1_q;
`endif
                end else begin
                    state_d = S_SHIFT_LO;
                    bit_d   = bit_q + 1'b1;
                    cnt_d   = DIV_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers and 2-FF synchronisers for the asynchronous pad data lines.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            pend_q  <= 1'b0;
            sync0_q <= 2'b11;
            sync1_q <= 2'b11;
            sr0_q   <= '0;
            sr1_q   <= '0;
            st0_q   <= '0;
            st1_q   <= '0;
            valid_q <= 1'b0;
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
            pr0_q   <= '0;
            pr1_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pend_q  <= pend_d;
            sync0_q <= {sync0_q[0], pad_data_0};
            sync1_q <= {sync1_q[0], pad_data_1};
            sr0_q   <= sr0_d;
            sr1_q   <= sr1_d;
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            valid_q <= valid_d;
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
            pr0_q   <= pr0_d;
            pr1_q   <= pr1_d;
`endif
        end
    end
endmodule

// File: tb/tb_pad_scan_controller.sv
// tb_pad_scan_controller: randomized checks of pad_scan_controller against a behavioural pad/scan model.
module tb_pad_scan_controller;
    localparam int L  = 96, D  = 48, B  = 16;
    localparam int LS = 2,  DS = 4,  BS = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn = 1'b0, frame_trigger = 1'b0, host_start = 1'b0;
    logic        pad_data_0, pad_data_1, pad_latch, pad_clk, busy, state_valid, scan_done;
    logic [15:0] pad_state_0, pad_state_1;
    logic        resetn_s = 1'b0, ft_s = 1'b0, hs_s = 1'b0;
    logic        pd0_s, pd1_s, lat_s, pclk_s, busy_s, val_s, done_s;
    logic [15:0] st0_s, st1_s;
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
    logic [15:0] pad_pressed_0, pad_pressed_1, pr0_s, pr1_s;
`endif

    pad_scan_controller dut (
        .clk(clk), .resetn(resetn), .frame_trigger(frame_trigger), .host_start(host_start),
        .pad_data_0(pad_data_0), .pad_data_1(pad_data_1), .pad_latch(pad_latch), .pad_clk(pad_clk),
        .pad_state_0(pad_state_0), .pad_state_1(pad_state_1), .busy(busy),
        .state_valid(state_valid), .scan_done(scan_done)
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
        , .pad_pressed_0(pad_pressed_0), .pad_pressed_1(pad_pressed_1)
`endif
    );

    pad_scan_controller #(.LATCH_CYCLES(LS), .CLK_DIV(DS), .SCAN_BITS(BS)) dut_s (
        .clk(clk), .resetn(resetn_s), .frame_trigger(ft_s), .host_start(hs_s),
        .pad_data_0(pd0_s), .pad_data_1(pd1_s), .pad_latch(lat_s), .pad_clk(pclk_s),
        .pad_state_0(st0_s), .pad_state_1(st1_s), .busy(busy_s),
        .state_valid(val_s), .scan_done(done_s)
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
        , .pad_pressed_0(pr0_s), .pad_pressed_1(pr1_s)
`endif
    );

    // Pad behaviour: latch rewinds to bit 0, each rising pad_clk advances one bit, data is active-low.
    logic [15:0] btn0 = '0, btn1 = '0, btn0_s = '0, btn1_s = '0;
    logic [4:0]  idx = '0, idx_s = '0;
    logic        pc_prev = 1'b1, pc_prev_s = 1'b1;
    always @(posedge clk) begin
        if (pad_latch === 1'b1) idx <= '0;
        else if (pad_clk === 1'b1 && pc_prev === 1'b0) idx <= idx + 5'd1;
        pc_prev <= pad_clk;
        if (lat_s === 1'b1) idx_s <= '0;
        else if (pclk_s === 1'b1 && pc_prev_s === 1'b0) idx_s <= idx_s + 5'd1;
        pc_prev_s <= pclk_s;
    end
    assign pad_data_0 = idx < 5'd16 ? ~btn0[idx[3:0]] : 1'b1;
    assign pad_data_1 = idx < 5'd16 ? ~btn1[idx[3:0]] : 1'b1;
    assign pd0_s      = idx_s < 5'd16 ? ~btn0_s[idx_s[3:0]] : 1'b1;
    assign pd1_s      = idx_s < 5'd16 ? ~btn1_s[idx_s[3:0]] : 1'b1;

    // Waveform statistics for the default-parameter instance.
    int   lat_cyc = 0, lo_cyc = 0, falls = 0, done_cnt = 0;
    logic pclk_m = 1'b1;
    always @(negedge clk) begin
        if (pad_latch === 1'b1) lat_cyc++;
        if (pad_clk === 1'b0) begin
            lo_cyc++;
            if (pclk_m === 1'b1) falls++;
        end
        if (scan_done === 1'b1) done_cnt++;
        pclk_m = pad_clk;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] m0 = '0, m1 = '0;
    logic        small_done = 1'b0;

    // Waits for the scan whose request cycle was cycle 0 (caller is now #1 into cycle 1), then checks it.
    task automatic finish_scan(input bit extra, input logic [15:0] b0, input logic [15:0] b1,
                               input int s_lat, input int s_lo, input int s_f);
        int   cyc = 1;
        int   tear = 0;
        logic got = 1'b0;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            if (extra) frame_trigger = (cyc % 400 == 100) && (cyc < 1300);
            if (scan_done === 1'b1) got = 1'b1;
            else begin
                if (pad_state_0 !== m0 || pad_state_1 !== m1) tear++;
                cyc++;
            end
        end
        frame_trigger = 1'b0;
        chk("scan_len", cyc, L + 2 * D * B + 1);
        chk("state0", 32'(pad_state_0), 32'(b0));
        chk("state1", 32'(pad_state_1), 32'(b1));
        chk("valid", 32'(state_valid), 1);
        chk("latch_cycles", lat_cyc - s_lat, L);
        chk("clk_low_cycles", lo_cyc - s_lo, D * B);
        chk("clk_periods", falls - s_f, B);
        chk("no_tear", tear, 0);
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
        chk("pressed0", 32'(pad_pressed_0), 32'(b0 & ~m0));
        chk("pressed1", 32'(pad_pressed_1), 32'(b1 & ~m1));
`endif
        m0 = b0;
        m1 = b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_fall", 32'(busy), 0);
        chk("done_single", 32'(scan_done), 0);
        chk("state0_hold", 32'(pad_state_0), 32'(m0));
        @(posedge clk); #1;
    endtask

    task automatic scan(input bit fr, input bit ho, input bit extra, input logic [15:0] b0, input logic [15:0] b1);
        int s_lat, s_lo, s_f;
        btn0 = b0; btn1 = b1;
        s_lat = lat_cyc; s_lo = lo_cyc; s_f = falls;
        frame_trigger = fr; host_start = ho;
        @(posedge clk); #1;
        frame_trigger = 1'b0; host_start = 1'b0;
        finish_scan(extra, b0, b1, s_lat, s_lo, s_f);
    endtask

    // Reduced-parameter instance: 12 bits, short latch and clock.
    initial begin
        logic [15:0] b, ms0;
        int          cyc;
        logic        got;
        ms0 = '0;
        repeat (3) @(posedge clk);
        #1 resetn_s = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b = k == 0 ? 16'hFFFF : 16'($urandom);
            btn0_s = b; btn1_s = ~b;
            ft_s = 1'b1;
            @(posedge clk); #1;
            ft_s = 1'b0;
            cyc = 1; got = 1'b0;
            while (!got && cyc < 500) begin
                @(negedge clk);
                if (done_s === 1'b1) got = 1'b1;
                else cyc++;
            end
            chk("s_len", cyc, LS + 2 * DS * BS + 1);
            chk("s_state0", 32'(st0_s), 32'(b & 16'h0FFF));
            chk("s_state1", 32'(st1_s), 32'(~b & 16'h0FFF));
`ifdef PAD_SCAN_CONTROLLER_EDGE_EN
            chk("s_pressed0", 32'(pr0_s), 32'(b & 16'h0FFF & ~ms0));
`endif
            ms0 = b & 16'h0FFF;
            repeat (3) @(posedge clk);
            #1;
        end
        small_done = 1'b1;
    end

    initial begin
        int          s_lat, s_lo, s_f, s_d;
        logic [15:0] r0, r1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_latch", 32'(pad_latch), 0);
        chk("rst_clk", 32'(pad_clk), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(state_valid), 0);
        chk("rst_done", 32'(scan_done), 0);
        chk("rst_state0", 32'(pad_state_0), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        scan(1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000);
        scan(1'b0, 1'b1, 1'b0, 16'h5555, 16'hAAAA);
        scan(1'b1, 1'b1, 1'b0, 16'h1234, 16'h8001);
        chk("single_scan", 32'(busy), 0);

        scan(1'b1, 1'b0, 1'b1, 16'h0F0F, 16'hF0F0);
        chk("pend_start_latch", 32'(pad_latch), 1);
        chk("pend_start_busy", 32'(busy), 1);
        btn0 = 16'hC3A5; btn1 = 16'h7E01;
        s_lat = lat_cyc; s_lo = lo_cyc; s_f = falls;
        finish_scan(1'b0, 16'hC3A5, 16'h7E01, s_lat, s_lo, s_f);
        chk("no_third_scan", 32'(busy), 0);

        btn0 = 16'hFFFF; btn1 = 16'hFFFF;
        s_f = falls;
        frame_trigger = 1'b1;
        @(posedge clk); #1;
        frame_trigger = 1'b0;
        for (int i = 0; i < 2500 && (falls - s_f) < 8; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_in_bit7_low", 32'(pad_clk), 0);
        s_d = done_cnt;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("abort_clk", 32'(pad_clk), 1);
        chk("abort_latch", 32'(pad_latch), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_state0", 32'(pad_state_0), 0);
        chk("abort_state1", 32'(pad_state_1), 0);
        chk("abort_valid", 32'(state_valid), 0);
        m0 = '0; m1 = '0;
        repeat (1700) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - s_d, 0);

        scan(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000);
        scan(1'b0, 1'b1, 1'b0, 16'h0006, 16'h0001);

        for (int k = 0; k < 4; k++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            scan(1'($urandom_range(0, 1)), 1'b1, 1'b0, r0, r1);
        end

        for (int i = 0; i < 10000 && !small_done; i++) @(posedge clk);
        chk("small_finished", 32'(small_done), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pad_scan_controller.md
Name: pad_scan_controller

Overview:
- Autonomous serial gamepad scanner that replaces the CPU bit-banging of pad latch/clock through the pad MMIO register.
- Runs one scan when `frame_trigger` fires (the VDP active-frame-ended pulse) or when the host requests one.
- Each scan drives the pads' latch and clock lines and samples two serial data lines. It publishes 16-bit button words atomically, which the bus arbiter's pad read source then reads.
- Runs entirely in the VDP clock domain.

Parameters:
- LATCH_CYCLES, 96, number of clk cycles `pad_latch` is held high per scan (must be ≥2).
- CLK_DIV, 48, clk cycles per half-period of `pad_clk` (must be ≥4).
- SCAN_BITS, 16, serial bits shifted per pad per scan (1..16; unused upper state bits read 0).

Ports:
- clk  input  1  VDP-domain clock.
- resetn  input  1  synchronous, active-low reset.
- frame_trigger  input  1  single-cycle pulse requesting a scan.
- host_start  input  1  single-cycle pulse from the MMIO write decode requesting a scan.
- pad_data_0  input  1  serial data from pad 0, active-low, asynchronous.
- pad_data_1  input  1  serial data from pad 1, active-low, asynchronous.
- pad_latch  output  1  latch strobe to both pads, active-high.
- pad_clk  output  1  shift clock to both pads; idles high.
- pad_state_0  output  16  pad 0 buttons; 1 = pressed; bit n = n-th serial bit.
- pad_state_1  output  16  pad 1 buttons, same format.
- busy  output  1  high while a scan is in progress.
- state_valid  output  1  sticky; set after the first completed scan.
- scan_done  output  1  single-cycle pulse when `pad_state_*` update.

Behaviour:
- Reset: clock and reset are as decided above (one clock; synchronous, active-low reset). When `resetn` is low at a clk edge, the following take effect at that edge and any scan in progress is aborted:
  - `pad_latch`=0, `pad_clk`=1, `pad_state_0`/`pad_state_1`=0.
  - `busy`=0, `state_valid`=0, `scan_done`=0.
  - Internal shift registers, counters and pending flag cleared; FSM=IDLE.
- Input synchronisation: `pad_data_0`/`pad_data_1` pass through 2-FF synchronisers; all sampling uses the synchronised value.
- FSM states: IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE.
- IDLE:
  - `pad_clk`=1, `pad_latch`=0, `busy`=0.
  - A request is `frame_trigger`, `host_start`, or the pending flag.
  - On a request: go to LATCH, clear pending, load the cycle counter, clear the bit counter.
  - `frame_trigger` and `host_start` asserted together = one scan.
- LATCH:
  - `pad_latch`=1 for exactly LATCH_CYCLES cycles, `busy`=1.
  - Then go to SHIFT_LO.
- SHIFT_LO:
  - `pad_clk`=0 for CLK_DIV cycles.
  - On the last cycle, sample the inverted synced data of each pad into bit[bit_cnt] of that pad's shift register.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - `pad_clk`=1 for CLK_DIV cycles (the rising edge advances the pad to its next bit).
  - Then: if bit_cnt = SCAN_BITS−1, go to DONE; else increment bit_cnt and go to SHIFT_LO.
- DONE (1 cycle):
  - Copy both shift registers to `pad_state_*` in the same cycle (no torn reads).
  - `scan_done`=1 for this cycle, set `state_valid`, go to IDLE.
  - `busy` falls on the next cycle.
- Scan length: LATCH_CYCLES + 2·CLK_DIV·SCAN_BITS + 1 cycles from the request edge to the `scan_done` pulse. Defaults: 1633.
- Requests while busy:
  - Any number of requests while busy set a single pending flag; they are not counted.
  - A pending request starts a new scan on the first IDLE cycle.
  - A request arriving in the DONE cycle is also queued.
- `pad_state_*` hold their values between scans; they are never cleared except by reset.
- Bits at or above SCAN_BITS always read 0.

Optional Feature:
- Macro: PAD_SCAN_CONTROLLER_EDGE_EN.
- When defined:
  - Adds outputs `pad_pressed_0` and `pad_pressed_1` (16-bit each).
  - In the DONE cycle each is loaded with `new_state & ~old_state`, i.e. newly pressed buttons.
  - Reset value 0; they hold until the next DONE.
  - The first scan after reset compares against 0.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then one `frame_trigger` pulse; pad 0 serial stream (active-low) 0,1,1,...,1 (B pressed), pad 1 all 1s → `pad_latch` high for 96 cycles, then 16 low/high `pad_clk` periods of 48/48 cycles; `scan_done` 1633 cycles after the trigger; `pad_state_0`=16'h0001, `pad_state_1`=16'h0000, `state_valid`=1.
2. Pad 0 stream alternates pressed/released starting at bit 0 → `pad_state_0`=16'h5555; both states change only in the `scan_done` cycle and hold afterwards.
3. `host_start` and `frame_trigger` asserted in the same cycle → exactly one scan. Then 3 `frame_trigger` pulses during that scan → exactly one additional scan, starting the cycle after `busy` falls.
4. `resetn` low for 1 cycle midway through SHIFT_LO of bit 7 → `pad_clk`=1, `pad_latch`=0, `busy`=0, states 0, `state_valid`=0 on the next cycle; no `scan_done`; a new trigger yields a full, correct scan.
5. SCAN_BITS=12, CLK_DIV=4, LATCH_CYCLES=2 with all bits pressed → `pad_state_0`=16'h0FFF; scan length 2+96+1=99 cycles.
6. PAD_SCAN_CONTROLLER_EDGE_EN defined; scan 1 state 16'h0003, scan 2 state 16'h0006 → `pad_pressed_0`=16'h0003 after scan 1, then 16'h0004 after scan 2.
